// File: rtl/ice51_pkg.sv
// Shared types and constants for the ice51 UART boot loader.
// CHECK/ERR loader states exist only with ICE51_UART_LOADER_CHECKSUM_EN.
package ice51_pkg;

  localparam int unsigned DEF_CLK_HZ = 12000000;
  localparam int unsigned DEF_BAUD   = 115200;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

`ifdef ICE51_UART_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    LD_LOAD,
    LD_RUN,
    LD_CHECK,
    LD_ERR
  } ld_state_e;
`else
  typedef enum logic [0:0] {
    LD_LOAD,
    LD_RUN
  } ld_state_e;
`endif

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/ice51_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// single-cycle byte_valid / frame_err strobes in the stop-sample cycle.
module ice51_uart_rx
  import ice51_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

  logic            meta_q;
  logic            sync_q;
  logic            prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  // Line flops reset low so a line held low across reset is not an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      meta_q  <= i_rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    o_valid     = 1'b0;
    o_frame_err = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (sync_q) begin
            o_valid = 1'b1;
            state_d = RX_IDLE;
          end else begin
            o_frame_err = 1'b1;
            state_d     = RX_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT: begin
        if (sync_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_data = shift_q;

endmodule

// File: rtl/ice51_uart_loader.sv
// UART boot loader: fills code memory with MEM_SIZE bytes, then runs the core.
// ICE51_UART_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module ice51_uart_loader
  import ice51_pkg::*;
#(
  parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
  parameter int unsigned BAUD      = DEF_BAUD,
  parameter int unsigned MEM_SIZE  = 512,
  parameter int unsigned SKIP_LOAD = 0,
  localparam int ADDR_W = $clog2(MEM_SIZE)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_uart_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data,
  output logic              o_cpu_run,
  output logic              o_rx_valid,
  output logic [7:0]        o_rx_data,
  output logic              o_frame_err,
  output logic              o_load_err
);

  localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);
  localparam ld_state_e RST_STATE = (SKIP_LOAD != 0) ? LD_RUN : LD_LOAD;
`ifdef ICE51_UART_LOADER_CHECKSUM_EN
  localparam ld_state_e DONE_STATE = LD_CHECK;
`else
  localparam ld_state_e DONE_STATE = LD_RUN;
`endif

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_err;

  ice51_uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx       (i_uart_rx),
    .o_valid    (byte_valid),
    .o_data     (byte_data),
    .o_frame_err(byte_err)
  );

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rxv_q, rxv_d;
  logic [7:0]        rxd_q, rxd_d;
  logic              ferr_q, ferr_d;
`ifdef ICE51_UART_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rxv_q   <= 1'b0;
      rxd_q   <= '0;
      ferr_q  <= 1'b0;
`ifdef ICE51_UART_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
      ferr_q  <= ferr_d;
`ifdef ICE51_UART_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Address advances in the write cycle so o_mem_addr shows the
  // address being written; the last address holds instead of wrapping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    rxv_d   = 1'b0;
    rxd_d   = rxd_q;
    ferr_d  = byte_err;
`ifdef ICE51_UART_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      LD_LOAD: begin
        if (byte_valid) begin
          we_d    = 1'b1;
          wdata_d = byte_data;
`ifdef ICE51_UART_LOADER_CHECKSUM_EN
          sum_d   = sum_q + byte_data;
`endif
        end
        if (we_q) begin
          if (addr_q == LAST) state_d = DONE_STATE;
          else addr_d = addr_q + ADDR_W'(1);
        end
      end
      LD_RUN: begin
        if (byte_valid) begin
          rxv_d = 1'b1;
          rxd_d = byte_data;
        end
      end
`ifdef ICE51_UART_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (byte_valid) state_d = (byte_data == sum_q) ? LD_RUN : LD_ERR;
      end
      LD_ERR: begin
        state_d = LD_ERR;
      end
`endif
    endcase
  end

  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_data  = wdata_q;
  assign o_cpu_run   = (state_q == LD_RUN);
  assign o_rx_valid  = rxv_q;
  assign o_rx_data   = rxd_q;
  assign o_frame_err = ferr_q;
`ifdef ICE51_UART_LOADER_CHECKSUM_EN
  assign o_load_err  = (state_q == LD_ERR);
`else
  assign o_load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ice51_uart_loader.sv
// Scoreboard bench for ice51_uart_loader with MEM_SIZE=4 at 115200 baud.
// Stimulus pushes expected events; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ice51_uart_loader;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       mem_we;
  logic [1:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_run;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       load_err;

  ice51_uart_loader #(
    .CLK_HZ   (12000000),
    .BAUD     (115200),
    .MEM_SIZE (4),
    .SKIP_LOAD(0)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_uart_rx  (rx),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_data),
    .o_cpu_run  (cpu_run),
    .o_rx_valid (rx_valid),
    .o_rx_data  (rx_data),
    .o_frame_err(frame_err),
    .o_load_err (load_err)
  );

  always #42 clk = ~clk;

  typedef enum int {EV_MEM, EV_RX, EV_FERR} ev_e;
  typedef struct {
    ev_e        kind;
    logic [1:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic mon(input ev_e k, input logic [1:0] a, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: kind %0d addr 0x%0h data 0x%0h, none required",
               k, a, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (e.kind == EV_MEM) check("mem_addr", a, e.addr);
      if (e.kind != EV_FERR) check("event_data", d, e.data);
    end
  endtask

  logic prev_last_we = 1'b0;
  logic prev_run     = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we)    mon(EV_MEM, mem_addr, mem_data);
      if (rx_valid)  mon(EV_RX, 2'd0, rx_data);
      if (frame_err) mon(EV_FERR, 2'd0, 8'h00);
`ifndef ICE51_UART_LOADER_CHECKSUM_EN
      if (cpu_run && !prev_run) check("run_rise_after_last_write", prev_last_we, 1);
      if (prev_last_we) check("run_one_cycle_after_write", cpu_run, 1);
`endif
    end
    prev_last_we = mem_we && (mem_addr == 2'd3) && !rst;
    prev_run     = cpu_run;
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                           input int stop_len);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic gap();
    repeat (20) @(negedge clk);
  endtask

  task automatic tx_mem(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back('{EV_MEM, a, d});
    send_byte(d, 1'b1, CPB);
    gap();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_data",  mem_data,  0);
    check("rst_cpu_run",   cpu_run,   0);
    check("rst_rx_valid",  rx_valid,  0);
    check("rst_rx_data",   rx_data,   0);
    check("rst_frame_err", frame_err, 0);
    check("rst_load_err",  load_err,  0);
    rst = 1'b0;
    gap();

    tx_mem(2'd0, 8'hA5);
    exp_q.push_back('{EV_FERR, 2'd0, 8'h00});
    send_byte(8'h77, 1'b0, CPB);
    gap();
    drain();
    check("addr_after_frame_err", mem_addr, 1);
    tx_mem(2'd1, 8'h12);
    drain();
    check("run_low_after_2_bytes", cpu_run, 0);

    pulse_reset();
    check("addr_after_reset", mem_addr, 0);
    check("run_after_reset",  cpu_run,  0);

    #20 rx = 1'b0;
    #40 rx = 1'b1;
    repeat (300) @(negedge clk);

    tx_mem(2'd0, 8'hA5);
    tx_mem(2'd1, 8'h00);
    tx_mem(2'd2, 8'hFF);
    check("run_low_before_4th", cpu_run, 0);
    tx_mem(2'd3, 8'h3C);
`ifdef ICE51_UART_LOADER_CHECKSUM_EN
    send_byte(8'hE0, 1'b1, CPB);
    gap();
`endif
    drain();
    check("run_after_load", cpu_run, 1);

    exp_q.push_back('{EV_RX, 2'd0, 8'h55});
    send_byte(8'h55, 1'b1, 60);
    exp_q.push_back('{EV_RX, 2'd0, 8'hC3});
    send_byte(8'hC3, 1'b1, CPB);
    gap();
    drain();
    check("rx_data_held", rx_data, 8'hC3);
    check("addr_frozen_in_run", mem_addr, 3);

`ifdef ICE51_UART_LOADER_CHECKSUM_EN
    pulse_reset();
    tx_mem(2'd0, 8'h01);
    tx_mem(2'd1, 8'h02);
    tx_mem(2'd2, 8'h03);
    tx_mem(2'd3, 8'h04);
    check("cs_run_before_sum", cpu_run, 0);
    send_byte(8'h0A, 1'b1, CPB);
    gap();
    check("cs_good_run", cpu_run, 1);
    check("cs_good_err", load_err, 0);

    pulse_reset();
    tx_mem(2'd0, 8'h01);
    tx_mem(2'd1, 8'h02);
    tx_mem(2'd2, 8'h03);
    tx_mem(2'd3, 8'h04);
    send_byte(8'h0B, 1'b1, CPB);
    gap();
    check("cs_bad_err", load_err, 1);
    begin
      int ran = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (cpu_run || !load_err) ran++;
      end
      check("cs_bad_held_1000", ran, 0);
    end
    send_byte(8'h99, 1'b1, CPB);
    gap();
    check("cs_err_sticky", load_err, 1);
    drain();
`endif

    repeat (50) @(negedge clk);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ice51_uart_loader.md
Name: ice51_uart_loader

Overview:
- Boot loader that sits between the external UART RX pin and the ice51 core / code memory.
- After reset it deserialises exactly MEM_SIZE bytes from i_uart_rx and writes them sequentially into code memory from address 0.
- It then releases the core (o_cpu_run) and forwards every later received byte to the core's serial receive path.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, truncated (104 at defaults).
- MEM_SIZE, 512, bytes to load; ADDR_W = $clog2(MEM_SIZE).
- SKIP_LOAD, 0, 1 = start directly in RUN with o_cpu_run=1 (preloaded-memory builds).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_uart_rx  in  1  asynchronous serial input; idle high.
- o_mem_we  out  1  code-memory write strobe, one cycle per byte.
- o_mem_addr  out  ADDR_W  write address.
- o_mem_data  out  8  write data.
- o_cpu_run  out  1  0 holds the core in reset; 1 lets it run.
- o_rx_valid  out  1  one-cycle pulse, RUN-mode byte available to the core.
- o_rx_data  out  8  RUN-mode byte; held until the next o_rx_valid.
- o_frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- o_load_err  out  1  sticky checksum failure (feature only; constant 0 otherwise).

Behaviour:
- Reset values: all outputs 0, o_mem_addr 0. Exception: o_cpu_run = 1 when SKIP_LOAD=1.
- Reset is synchronous. Asserting it mid-byte or mid-load discards any partial byte and returns to LOAD at address 0.
- RX synchroniser: i_uart_rx passes through 2 flops; all decisions use the synchronised signal.
- RX FSM states:
  - IDLE: wait for a falling edge of the synchronised line, i.e. previous sample 1 and current 0. A line held low through reset release does not start a frame until it has been seen high.
  - START: count CLKS_PER_BIT/2. If the line is still low, go to DATA; if high, treat as a glitch and return to IDLE.
  - DATA: sample at each CLKS_PER_BIT interval, 8 bits, LSB first.
  - STOP: sample after one CLKS_PER_BIT interval.
    - Line high: byte_valid pulses for one cycle.
    - Line low: o_frame_err pulses, the byte is dropped, and the FSM waits for the line to go high before returning to IDLE.
- Loader FSM, LOAD → RUN (plus CHECK/ERR with the feature):
  - LOAD: each byte_valid causes, on the next cycle, o_mem_we=1 with o_mem_data=byte and o_mem_addr=current count. The count increments after the write.
  - The write at address MEM_SIZE-1 moves to RUN; o_cpu_run rises on the cycle after that write. The count does not wrap.
  - RUN: byte_valid causes, on the next cycle, o_rx_valid=1 and o_rx_data=byte. o_mem_we never asserts again.
  - RUN is left only by reset.
- Timing: latency from the mid-stop-bit sample to o_mem_we / o_rx_valid is exactly 1 cycle.
- Minimum byte spacing is one full frame. Back-to-back frames, a new start bit immediately after the stop sample, must be accepted.

Optional Feature:
- Macro: ICE51_UART_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the MEM_SIZE-th write, enter CHECK and wait for one more byte (no memory write).
  - That byte must equal the 8-bit modulo-256 sum of all loaded bytes.
  - Match: go to RUN.
  - Mismatch: go to ERR. o_load_err=1 (sticky), o_cpu_run stays 0, and all further bytes are ignored until reset.
- Without the macro: there is no CHECK or ERR state and o_load_err is tied to 0.

Decomposition:
- Shared package ice51_pkg holds:
  - loader state encodings;
  - the RX FSM state encodings;
  - the CLKS_PER_BIT derivation function;
  - the default CLK_HZ and BAUD constants.
- One sub-module, ice51_uart_rx, holds the synchroniser, the RX FSM, byte_valid/byte_data and frame_err. It is reused by ice51_top for any other serial input.

Test Plan:
- Load MEM_SIZE=4 with bytes 0xA5,0x00,0xFF,0x3C at 115200 baud:
  - 4 o_mem_we pulses at addr 0..3 with matching data;
  - o_cpu_run rises 1 cycle after the addr-3 write.
- After RUN, send 0x55:
  - o_rx_valid pulses once with o_rx_data=0x55;
  - no o_mem_we.
- Send a frame with the stop bit forced low mid-load:
  - o_frame_err pulses once and o_mem_addr is unchanged;
  - the next good byte 0x12 is written at that same address.
- 40 ns low glitch on i_uart_rx in IDLE: no byte_valid, no frame_err.
- Assert i_rst for 1 cycle after 2 of 4 bytes, then reload 4 bytes:
  - writes restart at addr 0;
  - o_cpu_run is 0 until the 4th write.
- Checksum, with ICE51_UART_LOADER_CHECKSUM_EN and bytes 0x01,0x02,0x03,0x04:
  - checksum 0x0A: o_cpu_run=1;
  - checksum 0x0B: o_load_err=1 and o_cpu_run stays 0 for 1000 cycles.
